// File: rtl/lookahead_input_port.sv
`default_nettype none
// ============================================================================
// Module   : lookahead_input_port (with helper look_ahead_xy)
// Brief    : Router input-port flit FIFO with look-ahead XY route computation.
//            Optional protocol checks are enabled with the ROUTE_CHECK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================

// Computes the XY output port at the neighbour reached through cur_port.
// Y grows towards SOUTH and X grows towards EAST.
module look_ahead_xy #(
   parameter int X_NODE_NUM = 4,
   parameter int Y_NODE_NUM = 4,
   parameter int SW_X_ADDR  = 2,
   parameter int SW_Y_ADDR  = 1,
   parameter int XW         = 2,
   parameter int YW         = 2
) (
   input  logic [2:0]    cur_port,
   input  logic [XW-1:0] dest_x,
   input  logic [YW-1:0] dest_y,
   output logic [2:0]    next_port
);
   localparam logic [2:0] c_LOCAL = 3'd0;
   localparam logic [2:0] c_EAST  = 3'd1;
   localparam logic [2:0] c_NORTH = 3'd2;
   localparam logic [2:0] c_WEST  = 3'd3;
   localparam logic [2:0] c_SOUTH = 3'd4;

   logic [XW-1:0] w_nx;
   logic [YW-1:0] w_ny;

   always_comb begin
      w_nx = XW'(SW_X_ADDR);
      w_ny = YW'(SW_Y_ADDR);
      case (cur_port)
         c_EAST:  w_nx = XW'(SW_X_ADDR) + XW'(1);
         c_WEST:  w_nx = XW'(SW_X_ADDR) - XW'(1);
         c_NORTH: w_ny = YW'(SW_Y_ADDR) - YW'(1);
         c_SOUTH: w_ny = YW'(SW_Y_ADDR) + YW'(1);
         default: ;
      endcase
      if (dest_x > w_nx)      next_port = c_EAST;
      else if (dest_x < w_nx) next_port = c_WEST;
      else if (dest_y > w_ny) next_port = c_SOUTH;
      else if (dest_y < w_ny) next_port = c_NORTH;
      else                    next_port = c_LOCAL;
   end
endmodule

module lookahead_input_port #(
   parameter int FLIT_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 4,
   parameter int X_NODE_NUM   = 4,
   parameter int Y_NODE_NUM   = 4,
   parameter int SW_X_ADDR    = 2,
   parameter int SW_Y_ADDR    = 1,
   parameter int PORT_NUM     = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   input  logic                  flit_in_we,
   output logic [FLIT_WIDTH-1:0] flit_out,
   output logic                  flit_out_valid,
   input  logic                  flit_out_rd,
   output logic [2:0]            cur_port_out,
   output logic                  full,
   output logic                  empty,
   output logic                  err_out
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = (X_NODE_NUM > 1) ? $clog2(X_NODE_NUM) : 1;
   localparam int YW = (Y_NODE_NUM > 1) ? $clog2(Y_NODE_NUM) : 1;
   localparam logic [2:0] c_LOCAL = 3'd0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUTE = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q, count_d;
   logic [1:0]            state_q, state_d;
   logic [2:0]            cur_port_q, cur_port_d;
   logic [2:0]            next_port_q, next_port_d;

   logic [FLIT_WIDTH-1:0] w_front;
   logic                  w_front_head, w_front_tail;
   logic [XW-1:0]         w_dest_x;
   logic [YW-1:0]         w_dest_y;
   logic [2:0]            w_la_port;
   logic                  w_pop, w_push, w_valid, w_route_start;

   assign w_front      = mem_q[rd_ptr_q];
   assign w_front_head = w_front[FLIT_WIDTH-1];
   assign w_front_tail = w_front[FLIT_WIDTH-2];
   assign w_dest_y     = w_front[YW-1:0];
   assign w_dest_x     = w_front[YW+XW-1:YW];

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(BUFFER_DEPTH));

   look_ahead_xy #(
      .X_NODE_NUM (X_NODE_NUM),
      .Y_NODE_NUM (Y_NODE_NUM),
      .SW_X_ADDR  (SW_X_ADDR),
      .SW_Y_ADDR  (SW_Y_ADDR),
      .XW         (XW),
      .YW         (YW)
   ) u_la (
      .cur_port  (w_front[FLIT_WIDTH-3:FLIT_WIDTH-5]),
      .dest_x    (w_dest_x),
      .dest_y    (w_dest_y),
      .next_port (w_la_port)
   );

`ifdef ROUTE_CHECK_EN
   logic w_self;
   logic err_q, err_d;
   // Set once the current packet's head has left, so a later head means a lost tail.
   logic head_sent_q, head_sent_d;
   assign w_self = (w_dest_x == XW'(SW_X_ADDR)) && (w_dest_y == YW'(SW_Y_ADDR));
   assign err_out = err_q;
`else
   assign err_out = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cur_port_d    = cur_port_q;
      next_port_d   = next_port_q;
      w_pop         = 1'b0;
      w_valid       = 1'b0;
      w_route_start = 1'b0;
`ifdef ROUTE_CHECK_EN
      err_d         = err_q;
      head_sent_d   = head_sent_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
`ifdef ROUTE_CHECK_EN
               if (w_front_head) begin
                  w_route_start = 1'b1;
               end else begin
                  w_pop = 1'b1;
                  err_d = 1'b1;
               end
`else
               w_route_start = 1'b1;
`endif
            end
         end
         ROUTE: state_d = SEND;
         SEND: begin
`ifdef ROUTE_CHECK_EN
            if (!empty && w_front_head && head_sent_q) begin
               err_d         = 1'b1;
               w_route_start = 1'b1;
            end else
`endif
            begin
               w_valid = !empty;
               if (w_valid && flit_out_rd) begin
                  w_pop = 1'b1;
`ifdef ROUTE_CHECK_EN
                  if (w_front_head) head_sent_d = 1'b1;
`endif
                  if (w_front_tail) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (w_route_start) begin
         state_d     = ROUTE;
         cur_port_d  = w_front[FLIT_WIDTH-3:FLIT_WIDTH-5];
         next_port_d = w_la_port;
`ifdef ROUTE_CHECK_EN
         head_sent_d = 1'b0;
         if (w_self) begin
            next_port_d = c_LOCAL;
            err_d       = 1'b1;
         end
`endif
      end
   end

   // A full FIFO still accepts a write when the same cycle pops a flit.
   assign w_push  = flit_in_we && (!full || w_pop);
   assign count_d = count_q + CW'(w_push) - CW'(w_pop);

   always_comb begin
      flit_out = w_front;
      if (w_front_head) flit_out[FLIT_WIDTH-3:FLIT_WIDTH-5] = next_port_q;
   end
   assign flit_out_valid = w_valid;
   assign cur_port_out   = cur_port_q;

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= flit_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         cur_port_q  <= c_LOCAL;
         next_port_q <= c_LOCAL;
`ifdef ROUTE_CHECK_EN
         err_q       <= 1'b0;
         head_sent_q <= 1'b0;
`endif
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q     <= count_d;
         state_q     <= state_d;
         cur_port_q  <= cur_port_d;
         next_port_q <= next_port_d;
`ifdef ROUTE_CHECK_EN
         err_q       <= err_d;
         head_sent_q <= head_sent_d;
`endif
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lookahead_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lookahead_input_port
// Brief    : Directed self-checking bench for lookahead_input_port (router 2,1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lookahead_input_port;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] flit_in;
   logic        flit_in_we;
   logic [31:0] flit_out;
   logic        flit_out_valid;
   logic        flit_out_rd;
   logic [2:0]  cur_port_out;
   logic        full, empty, err_out;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   lookahead_input_port #(
      .FLIT_WIDTH(32), .BUFFER_DEPTH(4), .X_NODE_NUM(4), .Y_NODE_NUM(4),
      .SW_X_ADDR(2), .SW_Y_ADDR(1), .PORT_NUM(5)
   ) dut (
      .clk(clk), .reset(reset), .flit_in(flit_in), .flit_in_we(flit_in_we),
      .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_rd(flit_out_rd),
      .cur_port_out(cur_port_out), .full(full), .empty(empty), .err_out(err_out)
   );

   function automatic logic [31:0] mk(input logic h, input logic t, input logic [2:0] p,
                                      input logic [22:0] pay, input logic [1:0] dx,
                                      input logic [1:0] dy);
      return {h, t, p, pay, dx, dy};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] f);
      flit_in    = f;
      flit_in_we = 1'b1;
      cyc();
      flit_in_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!flit_out_valid && n < 20) begin
         cyc();
         n++;
      end
      total_cnt++;
      if (flit_out_valid !== 1'b1) $display("FAIL %s timeout: flit_out_valid=%b required 1", name, flit_out_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      flit_in = '0; flit_in_we = 1'b0; flit_out_rd = 1'b0;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      total_cnt++;
      if ({flit_out_valid, cur_port_out, full, empty, err_out} !== 7'b0_000_010)
         $display("FAIL reset_state: valid=%b cur=%0d full=%b empty=%b err=%b required 0 0 0 1 0",
                  flit_out_valid, cur_port_out, full, empty, err_out);
      else pass_cnt++;
   endtask

   task automatic test_single_latency();
      wr(mk(1, 1, 3'd1, 23'h1234, 2'd3, 2'd1));
      total_cnt++;
      if (flit_out_valid !== 1'b0 || empty !== 1'b0) $display("FAIL lat_edge0: valid=%b empty=%b required 0 0", flit_out_valid, empty);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b0 || cur_port_out !== 3'd1) $display("FAIL lat_route: valid=%b cur=%0d required 0 1", flit_out_valid, cur_port_out);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b1 || flit_out !== mk(1, 1, 3'd0, 23'h1234, 2'd3, 2'd1))
         $display("FAIL lat_send: valid=%b flit=%h required 1 %h", flit_out_valid, flit_out, mk(1, 1, 3'd0, 23'h1234, 2'd3, 2'd1));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
      cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b0 || empty !== 1'b1 || cur_port_out !== 3'd1)
         $display("FAIL lat_idle: valid=%b empty=%b cur=%0d required 0 1 1", flit_out_valid, empty, cur_port_out);
      else pass_cnt++;
   endtask

   task automatic test_burst();
      logic [31:0] exp [4];
      exp[0] = mk(1, 0, 3'd3, 23'h0AAAA, 2'd0, 2'd3);
      exp[1] = mk(0, 0, 3'd5, 23'h11111, 2'd1, 2'd2);
      exp[2] = mk(0, 0, 3'd6, 23'h22222, 2'd2, 2'd1);
      exp[3] = mk(0, 1, 3'd7, 23'h33333, 2'd3, 2'd0);
      wr(mk(1, 0, 3'd3, 23'h0AAAA, 2'd0, 2'd3));
      wr(exp[1]); wr(exp[2]); wr(exp[3]);
      wait_valid("burst");
      flit_out_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (flit_out_valid !== 1'b1 || flit_out !== exp[i])
            $display("FAIL burst_flit%0d: valid=%b flit=%h required 1 %h", i, flit_out_valid, flit_out, exp[i]);
         else pass_cnt++;
         cyc();
      end
      flit_out_rd = 1'b0;
      total_cnt++;
      if (empty !== 1'b1 || flit_out_valid !== 1'b0) $display("FAIL burst_end: empty=%b valid=%b required 1 0", empty, flit_out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      wr(mk(1, 1, 3'd4, 23'h00A, 2'd2, 2'd3));
      wr(mk(1, 1, 3'd2, 23'h00B, 2'd2, 2'd0));
      wait_valid("b2b_a");
      total_cnt++;
      if (flit_out !== mk(1, 1, 3'd4, 23'h00A, 2'd2, 2'd3) || cur_port_out !== 3'd4)
         $display("FAIL b2b_a: flit=%h cur=%0d required %h 4", flit_out, cur_port_out, mk(1, 1, 3'd4, 23'h00A, 2'd2, 2'd3));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
      total_cnt++;
      if (flit_out_valid !== 1'b0) $display("FAIL b2b_gap1: valid=%b required 0", flit_out_valid);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b0 || cur_port_out !== 3'd2) $display("FAIL b2b_gap2: valid=%b cur=%0d required 0 2", flit_out_valid, cur_port_out);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b1 || flit_out !== mk(1, 1, 3'd0, 23'h00B, 2'd2, 2'd0))
         $display("FAIL b2b_b: valid=%b flit=%h required 1 %h", flit_out_valid, flit_out, mk(1, 1, 3'd0, 23'h00B, 2'd2, 2'd0));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
   endtask

   task automatic test_full();
      logic [31:0] exp [4];
      exp[0] = mk(0, 0, 3'd0, 23'h00B1, 2'd0, 2'd0);
      exp[1] = mk(0, 0, 3'd0, 23'h00B2, 2'd0, 2'd0);
      exp[2] = mk(0, 0, 3'd0, 23'h00B3, 2'd0, 2'd0);
      exp[3] = mk(0, 1, 3'd0, 23'h00EE, 2'd0, 2'd0);
      wr(mk(1, 0, 3'd1, 23'h00F0, 2'd3, 2'd1));
      wr(exp[0]); wr(exp[1]); wr(exp[2]);
      total_cnt++;
      if (full !== 1'b1 || flit_out_valid !== 1'b1 || flit_out !== mk(1, 0, 3'd0, 23'h00F0, 2'd3, 2'd1))
         $display("FAIL full_set: full=%b valid=%b flit=%h required 1 1 %h", full, flit_out_valid, flit_out, mk(1, 0, 3'd0, 23'h00F0, 2'd3, 2'd1));
      else pass_cnt++;
      wr(mk(0, 1, 3'd0, 23'h0DDD, 2'd0, 2'd0));
      flit_in = exp[3]; flit_in_we = 1'b1; flit_out_rd = 1'b1;
      cyc();
      flit_in_we = 1'b0;
      total_cnt++;
      if (full !== 1'b1) $display("FAIL full_rw: full=%b required 1", full);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (flit_out_valid !== 1'b1 || flit_out !== exp[i])
            $display("FAIL full_drain%0d: valid=%b flit=%h required 1 %h", i, flit_out_valid, flit_out, exp[i]);
         else pass_cnt++;
         cyc();
      end
      flit_out_rd = 1'b0;
      total_cnt++;
      if (empty !== 1'b1) $display("FAIL full_empty: empty=%b required 1", empty);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_packet();
      wr(mk(1, 0, 3'd3, 23'h0777, 2'd0, 2'd3));
      wr(mk(0, 0, 3'd0, 23'h0001, 2'd0, 2'd0));
      wr(mk(0, 0, 3'd0, 23'h0002, 2'd0, 2'd0));
      wr(mk(0, 1, 3'd0, 23'h0003, 2'd0, 2'd0));
      wait_valid("rst_mid");
      flit_out_rd = 1'b1;
      cyc(); cyc();
      flit_out_rd = 1'b0;
      do_reset();
      total_cnt++;
      if (empty !== 1'b1 || flit_out_valid !== 1'b0 || full !== 1'b0 || cur_port_out !== 3'd0)
         $display("FAIL rst_mid_state: empty=%b valid=%b full=%b cur=%0d required 1 0 0 0", empty, flit_out_valid, full, cur_port_out);
      else pass_cnt++;
      wr(mk(1, 1, 3'd2, 23'h0555, 2'd2, 2'd0));
      cyc(); cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b1 || flit_out !== mk(1, 1, 3'd0, 23'h0555, 2'd2, 2'd0) || cur_port_out !== 3'd2)
         $display("FAIL rst_mid_new: valid=%b flit=%h cur=%0d required 1 %h 2", flit_out_valid, flit_out, cur_port_out, mk(1, 1, 3'd0, 23'h0555, 2'd2, 2'd0));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
   endtask

`ifdef ROUTE_CHECK_EN
   task automatic test_route_check();
      do_reset();
      wr(mk(0, 0, 3'd1, 23'h0BAD, 2'd3, 2'd1));
      cyc();
      total_cnt++;
      if (empty !== 1'b1 || err_out !== 1'b1 || flit_out_valid !== 1'b0)
         $display("FAIL chk_body: empty=%b err=%b valid=%b required 1 1 0", empty, err_out, flit_out_valid);
      else pass_cnt++;
      do_reset();
      total_cnt++;
      if (err_out !== 1'b0) $display("FAIL chk_err_clear: err=%b required 0", err_out);
      else pass_cnt++;
      wr(mk(1, 1, 3'd0, 23'h0C0C, 2'd2, 2'd1));
      wait_valid("chk_self");
      total_cnt++;
      if (flit_out !== mk(1, 1, 3'd0, 23'h0C0C, 2'd2, 2'd1) || err_out !== 1'b1)
         $display("FAIL chk_self: flit=%h err=%b required %h 1", flit_out, err_out, mk(1, 1, 3'd0, 23'h0C0C, 2'd2, 2'd1));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
   endtask
`else
   task automatic test_no_check();
      wr(mk(0, 1, 3'd1, 23'h0BEE, 2'd3, 2'd1));
      cyc(); cyc();
      total_cnt++;
      if (flit_out_valid !== 1'b1 || flit_out !== mk(0, 1, 3'd1, 23'h0BEE, 2'd3, 2'd1) || cur_port_out !== 3'd1 || err_out !== 1'b0)
         $display("FAIL nochk_body: valid=%b flit=%h cur=%0d err=%b required 1 %h 1 0",
                  flit_out_valid, flit_out, cur_port_out, err_out, mk(0, 1, 3'd1, 23'h0BEE, 2'd3, 2'd1));
      else pass_cnt++;
      flit_out_rd = 1'b1;
      cyc();
      flit_out_rd = 1'b0;
      total_cnt++;
      if (empty !== 1'b1) $display("FAIL nochk_empty: empty=%b required 1", empty);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_latency();
      test_burst();
      test_back_to_back();
      test_full();
      test_reset_mid_packet();
`ifdef ROUTE_CHECK_EN
      test_route_check();
`else
      test_no_check();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
